// File: rtl/ps2_event_receiver.sv
// ps2_event_receiver
//   PS/2 device receiver producing key events into a ready/valid FIFO.
//   Raw PS2Clk/PS2Data are 2-FF synchronised; PS2Clk is deglitched by a
//   run-length filter and its falling edge is the bit sample strobe. Frames
//   (start, 8 data LSB first, odd parity, stop) are checked, stalled frames
//   time out, and F0/E0 prefixes are folded into the event that follows.
//
//   Optional feature macro: PS2_EXT_CODE_EN
//     defined     : E0 prefix sets the extended flag and is not pushed.
//     not defined : E0 is pushed as an ordinary code; EvExt is tied 0.
//
// Ports
//   Clock     in   system clock, rising edge
//   Reset     in   synchronous active-high reset
//   PS2Clk    in   asynchronous PS/2 clock
//   PS2Data   in   asynchronous PS/2 data
//   EvValid   out  FIFO head holds an event
//   EvReady   in   consumer accepts head when EvValid && EvReady
//   EvCode    out  scan code of head event (0 when empty)
//   EvBreak   out  head event is a release
//   EvExt     out  head event is extended
//   FrameErr  out  1-cycle pulse on framing/parity error or timeout
//   Overflow  out  sticky: an event was dropped on a full FIFO
//   Count     out  FIFO occupancy
module ps2_event_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             PS2Clk,
  input  logic             PS2Data,
  output logic             EvValid,
  input  logic             EvReady,
  output logic [7:0]       EvCode,
  output logic             EvBreak,
  output logic             EvExt,
  output logic             FrameErr,
  output logic             Overflow,
  output logic [CNT_W-1:0] Count
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef PS2_EXT_CODE_EN
  localparam int ENT_W = 10;
`else
  localparam int ENT_W = 9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- sync
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2Clk;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2Data;
      dat_s2 <= dat_s1;
    end
  end

  // -------------------------------------------------------------- filter
  // filt_cnt counts consecutive samples differing from the filtered level;
  // the level flips on the FILTER_LEN-th one. A fall raises strobe for one
  // cycle and captures the data bit alongside it.
  logic             filt_clk;
  logic [FLT_W-1:0] filt_cnt;
  logic             strobe;
  logic             smp_bit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
      smp_bit  <= 1'b1;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        if (!clk_s2) begin
          strobe  <= 1'b1;
          smp_bit <= dat_s2;
        end
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- FSM
  state_t          state, state_nx;
  logic [7:0]      shreg;
  logic [2:0]      bitcnt;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            frame_err_nx;
  logic            byte_ok;
  logic            timeout;

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    frame_err_nx = 1'b0;
    byte_ok      = 1'b0;
    timeout      = 1'b0;
    if (strobe) begin
      case (state)
        S_IDLE: begin
          if (!smp_bit) state_nx = S_DATA;
          else          frame_err_nx = 1'b1;
        end
        S_DATA: begin
          if (bitcnt == 3'd7) state_nx = S_PARITY;
        end
        S_PARITY: state_nx = S_STOP;
        S_STOP: begin
          state_nx = S_IDLE;
          if (smp_bit && (^{shreg, par_bit})) byte_ok = 1'b1;
          else                                frame_err_nx = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (state != S_IDLE && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
      timeout      = 1'b1;
      frame_err_nx = 1'b1;
      state_nx     = S_IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shreg    <= '0;
      bitcnt   <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      FrameErr <= 1'b0;
    end else begin
      FrameErr <= frame_err_nx;
      if (strobe || state == S_IDLE) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;
      if (strobe) begin
        case (state)
          S_IDLE:   bitcnt <= '0;
          S_DATA: begin
            shreg  <= {smp_bit, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          S_PARITY: par_bit <= smp_bit;
          default: ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------- decode
  logic             break_pend;
  logic             is_brk;
  logic             is_ext;
  logic             push;
  logic [ENT_W-1:0] push_data;

  assign is_brk = (shreg == 8'hF0);
`ifdef PS2_EXT_CODE_EN
  logic ext_pend;
  assign is_ext    = (shreg == 8'hE0);
  assign push_data = {ext_pend, break_pend, shreg};
`else
  assign is_ext    = 1'b0;
  assign push_data = {break_pend, shreg};
`endif
  assign push = byte_ok && !is_brk && !is_ext;

  always_ff @(posedge Clock) begin
    if (Reset || timeout) begin
      break_pend <= 1'b0;
`ifdef PS2_EXT_CODE_EN
      ext_pend   <= 1'b0;
`endif
    end else if (byte_ok) begin
      if (is_brk) begin
        break_pend <= 1'b1;
      end else if (is_ext) begin
`ifdef PS2_EXT_CODE_EN
        ext_pend   <= 1'b1;
`endif
      end else begin
        break_pend <= 1'b0;
`ifdef PS2_EXT_CODE_EN
        ext_pend   <= 1'b0;
`endif
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, pop, push_eff;
  logic [ENT_W-1:0] head;

  assign EvValid  = (Count != '0);
  assign full     = (Count == CNT_W'(FIFO_DEPTH));
  assign pop      = EvValid && EvReady;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_eff = push && (!full || pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (push_eff) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: ;
      endcase
      if (push && !push_eff) Overflow <= 1'b1;
    end
  end

  assign EvCode  = EvValid ? head[7:0] : '0;
  assign EvBreak = EvValid & head[8];
`ifdef PS2_EXT_CODE_EN
  assign EvExt   = EvValid & head[9];
`else
  assign EvExt   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_event_receiver.sv
// Testbench for ps2_event_receiver. PS/2 bit period is shortened to 40 clock
// cycles so the run stays short; filter/timeout/FIFO parameters are defaults.
module tb_ps2_event_receiver;

  localparam int DEPTH = 8;
  localparam int HALF  = 20;
  localparam int GAP   = 30;
`ifdef PS2_EXT_CODE_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic       EvValid;
  logic       EvReady = 1'b0;
  logic [7:0] EvCode;
  logic       EvBreak;
  logic       EvExt;
  logic       FrameErr;
  logic       Overflow;
  logic [3:0] Count;

  ps2_event_receiver #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(5000),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (4)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .PS2Clk  (PS2Clk),
    .PS2Data (PS2Data),
    .EvValid (EvValid),
    .EvReady (EvReady),
    .EvCode  (EvCode),
    .EvBreak (EvBreak),
    .EvExt   (EvExt),
    .FrameErr(FrameErr),
    .Overflow(Overflow),
    .Count   (Count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  // reference model state
  ev_t expq[$];
  bit  m_brk = 1'b0;
  bit  m_ext = 1'b0;
  bit  ovf_exp = 1'b0;
  int  fe_exp = 0;
  int  fe_seen = 0;
  bit  fe_prev = 1'b0;
  int  ready_mode = 0;  // 0: hold low, 1: hold high, 2: random

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  always @(posedge Clock) begin
    #1;
    case (ready_mode)
      0:       EvReady = 1'b0;
      1:       EvReady = 1'b1;
      default: EvReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Model of accepted bytes: prefixes accumulate, anything else is an event.
  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (EXT_EN && b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      e.code = b;
      e.brk  = m_brk;
      e.ext  = m_ext;
      if (ready_mode == 0 && expq.size() == DEPTH) ovf_exp = 1'b1;
      else expq.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic d, input bit glitch);
    PS2Data = d;
    cyc(HALF);
    PS2Clk = 1'b0;
    if (glitch) begin
      cyc(14);
      PS2Clk = 1'b1;
      cyc(2);
      PS2Clk = 1'b0;
      cyc(HALF - 16);
    end else begin
      cyc(HALF);
    end
    PS2Clk = 1'b1;
  endtask

  // err: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [7:0] b, input int err, input int gbit);
    logic [10:0] bits;
    bits = {(err == 2) ? 1'b0 : 1'b1, (~^b) ^ (err == 1), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        if (err != 0) fe_exp++;
        else model_byte(b);
      end
      ps2_bit(bits[i], i == gbit);
    end
    PS2Data = 1'b1;
    cyc(GAP);
  endtask

  task automatic send_partial(input int ndata);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < ndata; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    PS2Data = 1'b1;
  endtask

  task automatic qcheck(input string name);
    check({name, "_count"}, 32'(Count), 32'(expq.size()));
    check({name, "_frameerr"}, 32'(fe_seen), 32'(fe_exp));
    check({name, "_overflow"}, 32'(Overflow), 32'(ovf_exp));
  endtask

  task automatic drain(input string name);
    ready_mode = 1;
    for (int i = 0; i < 2000 && (expq.size() != 0 || EvValid); i++) cyc(1);
    ready_mode = 0;
    cyc(2);
    check({name, "_drained"}, {31'd0, EvValid}, 32'd0);
    qcheck(name);
  endtask

  // Per-cycle comparison of the FIFO head against the model queue.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (FrameErr) begin
        fe_seen++;
        if (fe_prev) check("frameerr_width", 32'd2, 32'd1);
      end
      fe_prev = FrameErr;
      if (EvValid) begin
        if (expq.size() == 0) begin
          check("unexpected_event", 32'(EvCode), 32'h1ff);
        end else begin
          check("head_code", 32'(EvCode), 32'(expq[0].code));
          check("head_break", 32'(EvBreak), 32'(expq[0].brk));
          check("head_ext", 32'(EvExt), 32'(expq[0].ext));
          if (EvReady) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    cyc(5);
    Reset = 1'b0;
    cyc(1);
    check("rst_valid", 32'(EvValid), 32'd0);
    check("rst_code", 32'(EvCode), 32'd0);
    check("rst_break", 32'(EvBreak), 32'd0);
    check("rst_ext", 32'(EvExt), 32'd0);
    check("rst_frameerr", 32'(FrameErr), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    check("rst_count", 32'(Count), 32'd0);

    // 1: 1C with a 2-cycle clock glitch inside data bit 4
    send_frame(8'h1C, 0, 5);
    check("t1_count", 32'(Count), 32'd1);
    check("t1_code", 32'(EvCode), 32'h1C);
    check("t1_break", 32'(EvBreak), 32'd0);
    check("t1_ext", 32'(EvExt), 32'd0);
    qcheck("t1");
    drain("t1");

    // 2: F0 alone gives nothing; then 5A released
    send_frame(8'hF0, 0, -1);
    check("t2_no_event", 32'(Count), 32'd0);
    send_frame(8'h5A, 0, -1);
    check("t2_code", 32'(EvCode), 32'h5A);
    check("t2_break", 32'(EvBreak), 32'd1);
    drain("t2");

    // 3: E0 F0 75
    send_frame(8'hE0, 0, -1);
    send_frame(8'hF0, 0, -1);
    send_frame(8'h75, 0, -1);
`ifdef PS2_EXT_CODE_EN
    check("t3_count", 32'(Count), 32'd1);
    check("t3_code", 32'(EvCode), 32'h75);
    check("t3_break", 32'(EvBreak), 32'd1);
    check("t3_ext", 32'(EvExt), 32'd1);
`else
    check("t3_count", 32'(Count), 32'd2);
    check("t3_code", 32'(EvCode), 32'hE0);
    check("t3_break", 32'(EvBreak), 32'd0);
    check("t3_ext", 32'(EvExt), 32'd0);
`endif
    qcheck("t3");
    drain("t3");

    // 4: bad parity then good 1C
    send_frame(8'h5A, 1, -1);
    check("t4_no_event", 32'(Count), 32'd0);
    check("t4_frameerr", 32'(fe_seen), 32'd1);
    send_frame(8'h1C, 0, -1);
    check("t4_code", 32'(EvCode), 32'h1C);
    drain("t4");

    // 5: stalled frame times out (flags cleared), next frame decodes
    send_frame(8'hF0, 0, -1);
    send_partial(5);
    cyc(5300);
    fe_exp++;
    m_brk = 1'b0;
    m_ext = 1'b0;
    qcheck("t5_timeout");
    send_frame(8'h1C, 0, -1);
    check("t5_code", 32'(EvCode), 32'h1C);
    check("t5_break", 32'(EvBreak), 32'd0);
    drain("t5");

    // stray clock fall with data high while idle
    fe_exp++;
    ps2_bit(1'b1, 1'b0);
    cyc(GAP);
    qcheck("stray");

    // 6: overflow with consumer stalled
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, -1);
    check("t6_count", 32'(Count), 32'd8);
    check("t6_overflow", 32'(Overflow), 32'd1);
    check("t6_head", 32'(EvCode), 32'h01);
    drain("t6");
    check("t6_overflow_sticky", 32'(Overflow), 32'd1);

    // reset mid-frame clears partial frame, prefix flag and Overflow
    send_frame(8'hF0, 0, -1);
    send_partial(3);
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    ovf_exp = 1'b0;
    cyc(2);
    qcheck("midrst");
    send_frame(8'h1C, 0, -1);
    check("midrst_code", 32'(EvCode), 32'h1C);
    check("midrst_break", 32'(EvBreak), 32'd0);
    drain("midrst");

    // random traffic with random consumer backpressure
    ready_mode = 2;
    for (int i = 0; i < 14; i++) begin
      logic [7:0] b;
      int         sel;
      int         err;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 8'hF0;
      else if (sel == 1) b = 8'hE0;
      else               b = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(b, err, -1);
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
